// File: rtl/rc4_pkg.sv
// Shared constants for the RC4 stream engine: FSM encodings and S-box geometry.
package rc4_pkg;

  // FSM encodings, kept as plain constants so legacy tools and checkers can bind to them.
  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_LOAD   = 3'd1;
  localparam logic [2:0] ST_INIT   = 3'd2;
  localparam logic [2:0] ST_KSA    = 3'd3;
  localparam logic [2:0] ST_DROP   = 3'd4;
  localparam logic [2:0] ST_STREAM = 3'd5;

  localparam int SBOX_DEPTH       = 256;
  localparam int INIT_CYCLES      = 256;
  // KSA steps and keystream bytes both take two cycles: A (index update) and B (swap).
  localparam int KSA_CYCLES_PER_I = 2;

endpackage

// File: rtl/rc4_sbox.sv
// RC4 permutation state: 256x8 registers, two combinational read ports,
// a dual-address swap write and an identity-fill write used during INIT.
module rc4_sbox
  import rc4_pkg::*;
(
  input  logic       clk,
  input  logic [7:0] i_rd_addr0,
  input  logic [7:0] i_rd_addr1,
  output logic [7:0] o_rd_data0,
  output logic [7:0] o_rd_data1,
  input  logic       i_swap_we,
  input  logic [7:0] i_swap_addr_a,
  input  logic [7:0] i_swap_data_a,
  input  logic [7:0] i_swap_addr_b,
  input  logic [7:0] i_swap_data_b,
  input  logic       i_init_we,
  input  logic [7:0] i_init_addr
);

  logic [7:0] r_mem [SBOX_DEPTH];

  assign o_rd_data0 = r_mem[i_rd_addr0];
  assign o_rd_data1 = r_mem[i_rd_addr1];

  // Identity fill has priority; a swap with equal addresses writes the same value twice.
  always_ff @(posedge clk) begin
    if (i_init_we) begin
      r_mem[i_init_addr] <= i_init_addr;
    end else if (i_swap_we) begin
      r_mem[i_swap_addr_a] <= i_swap_data_a;
      r_mem[i_swap_addr_b] <= i_swap_data_b;
    end
  end

endmodule

// File: rtl/rc4_stream_engine.sv
// RC4 engine: variable-length key load, S-box init, KSA, optional drop-N,
// then XOR of a back-pressured byte stream with the keystream.
//
// Handshakes: a byte moves on any rising edge where valid & ready are both 1.
// A producer holds valid and data stable until that edge; ready may depend
// combinationally on state and on dout_ready, never on the same port's valid.
module rc4_stream_engine
  import rc4_pkg::*;
#(
  parameter int KEY_MAX = 16,
  parameter int DROP_N  = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       key_valid,
  output logic       key_ready,
  input  logic [7:0] key_data,
  input  logic       key_last,
  input  logic       din_valid,
  output logic       din_ready,
  input  logic [7:0] din_data,
  output logic       dout_valid,
  input  logic       dout_ready,
  output logic [7:0] dout_data,
  output logic       busy,
  output logic       key_err,
  output logic [2:0] dbg_state
);

  localparam int KW      = (KEY_MAX > 1) ? $clog2(KEY_MAX) : 1;
  localparam int PHASE_W = $clog2(KSA_CYCLES_PER_I);
  localparam logic [KW:0]        KLEN_MAX   = KEY_MAX[KW:0];
  localparam logic [11:0]        DROP_LAST  = 12'(DROP_N - 1);
  localparam logic [PHASE_W-1:0] PH_A       = '0;
  localparam logic [PHASE_W-1:0] PH_B       = PHASE_W'(KSA_CYCLES_PER_I - 1);

  logic [2:0]         r_state;
  logic [PHASE_W-1:0] r_phase;
  logic [7:0]         r_i, r_j, r_si, r_sj, r_ks, r_dout_data;
  logic               r_ks_valid, r_dout_valid, r_key_err;
  logic [KW:0]        r_klen;
  logic [KW-1:0]      r_kidx;
  logic [11:0]        r_drop_cnt;
  logic [7:0]         r_key [KEY_MAX];

  logic [7:0] w_rd_addr0, w_rd_addr1, w_rd_data0, w_rd_data1;
  logic [7:0] w_j_next, w_t, w_ks, w_key_byte;
  logic       w_key_hs, w_din_hs, w_in_gen, w_ksa_b, w_gen_a, w_gen_b;

  assign key_ready  = (r_state == ST_LOAD);
  assign din_ready  = r_ks_valid & (~r_dout_valid | dout_ready);
  assign dout_valid = r_dout_valid;
  assign dout_data  = r_dout_data;
  assign key_err    = r_key_err;
  assign busy       = (r_state == ST_LOAD) | (r_state == ST_INIT) |
                      (r_state == ST_KSA)  | (r_state == ST_DROP);
  assign dbg_state  = r_state;

  assign w_key_hs   = key_valid & key_ready;
  assign w_din_hs   = din_valid & din_ready;
  assign w_in_gen   = (r_state == ST_DROP) | (r_state == ST_STREAM);
  assign w_ksa_b    = (r_state == ST_KSA) & (r_phase == PH_B);
  assign w_gen_a    = w_in_gen & (r_phase == PH_A);
  // Phase B waits for the holding register to empty; phase A may run ahead.
  assign w_gen_b    = w_in_gen & (r_phase == PH_B) & ~r_ks_valid;
  assign w_key_byte = r_key[r_kidx];

  // Phase A reads S[i] (KSA) or S[i+1] (generation) and chains the new j into port 1.
  assign w_j_next   = r_j + w_rd_data0 + ((r_state == ST_KSA) ? w_key_byte : 8'd0);
  assign w_rd_addr1 = w_j_next;
  assign w_t        = r_si + r_sj;

  // Port 0 serves the i-side read in phase A and the output lookup S[t] in phase B.
  always_comb begin
    w_rd_addr0 = (r_state == ST_KSA) ? r_i : (r_i + 8'd1);
    if (w_in_gen && (r_phase == PH_B)) w_rd_addr0 = w_t;
  end

  // The lookup happens in the same cycle as the swap, so forward the post-swap values.
  assign w_ks = (w_t == r_i) ? r_sj : (w_t == r_j) ? r_si : w_rd_data0;

  rc4_sbox u_sbox (
    .clk           (clk),
    .i_rd_addr0    (w_rd_addr0),
    .i_rd_addr1    (w_rd_addr1),
    .o_rd_data0    (w_rd_data0),
    .o_rd_data1    (w_rd_data1),
    .i_swap_we     (w_ksa_b | w_gen_b),
    .i_swap_addr_a (r_i),
    .i_swap_data_a (r_sj),
    .i_swap_addr_b (r_j),
    .i_swap_data_b (r_si),
    .i_init_we     (r_state == ST_INIT),
    .i_init_addr   (r_i)
  );

  // Key byte storage; bytes past KEY_MAX are not stored.
  always_ff @(posedge clk) begin
    if (!rst && !start && w_key_hs && (r_klen < KLEN_MAX)) begin
      r_key[r_klen[KW-1:0]] <= key_data;
    end
  end

  // Session FSM, index registers, keystream holding register and output register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_phase      <= PH_A;
      r_i          <= 8'd0;
      r_j          <= 8'd0;
      r_si         <= 8'd0;
      r_sj         <= 8'd0;
      r_ks         <= 8'd0;
      r_ks_valid   <= 1'b0;
      r_dout_valid <= 1'b0;
      r_dout_data  <= 8'd0;
      r_key_err    <= 1'b0;
      r_klen       <= '0;
      r_kidx       <= '0;
      r_drop_cnt   <= 12'd0;
    end else if (start) begin
      r_state      <= ST_LOAD;
      r_phase      <= PH_A;
      r_i          <= 8'd0;
      r_j          <= 8'd0;
      r_ks_valid   <= 1'b0;
      r_dout_valid <= 1'b0;
      r_dout_data  <= 8'd0;
      r_key_err    <= 1'b0;
      r_klen       <= '0;
      r_kidx       <= '0;
      r_drop_cnt   <= 12'd0;
    end else begin
      if (w_din_hs) begin
        r_dout_data  <= din_data ^ r_ks;
        r_dout_valid <= 1'b1;
        r_ks_valid   <= 1'b0;
      end else if (r_dout_valid && dout_ready) begin
        r_dout_valid <= 1'b0;
      end

      case (r_state)
        ST_IDLE: ;
        ST_LOAD: begin
          if (w_key_hs) begin
            if (r_klen < KLEN_MAX) r_klen <= r_klen + 1'b1;
            else                   r_key_err <= 1'b1;
            if (key_last) begin
              r_state <= ST_INIT;
              r_i     <= 8'd0;
            end
          end
        end
        ST_INIT: begin
          r_i <= r_i + 8'd1;
          if (r_i == 8'(INIT_CYCLES - 1)) begin
            r_state <= ST_KSA;
            r_j     <= 8'd0;
            r_kidx  <= '0;
            r_phase <= PH_A;
          end
        end
        ST_KSA: begin
          if (r_phase == PH_A) begin
            r_j     <= w_j_next;
            r_si    <= w_rd_data0;
            r_sj    <= w_rd_data1;
            r_phase <= PH_B;
          end else begin
            r_phase <= PH_A;
            r_i     <= r_i + 8'd1;
            r_kidx  <= ({1'b0, r_kidx} == (r_klen - 1'b1)) ? '0 : (r_kidx + 1'b1);
            if (r_i == 8'(SBOX_DEPTH - 1)) begin
              r_j        <= 8'd0;
              r_drop_cnt <= 12'd0;
              r_state    <= (DROP_N == 0) ? ST_STREAM : ST_DROP;
            end
          end
        end
        ST_DROP, ST_STREAM: begin
          if (w_gen_a) begin
            r_i     <= r_i + 8'd1;
            r_j     <= w_j_next;
            r_si    <= w_rd_data0;
            r_sj    <= w_rd_data1;
            r_phase <= PH_B;
          end else if (w_gen_b) begin
            r_phase <= PH_A;
            if (r_state == ST_DROP) begin
              r_drop_cnt <= r_drop_cnt + 12'd1;
              if (r_drop_cnt == DROP_LAST) r_state <= ST_STREAM;
            end else begin
              r_ks       <= w_ks;
              r_ks_valid <= 1'b1;
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rc4_stream_engine.sv
// Bench for rc4_stream_engine: three instances (plain, drop-3, KEY_MAX=4)
// checked against a behavioural RC4 model built from arrays and queues.
module tb_rc4_stream_engine;
  import rc4_pkg::*;

  typedef logic [7:0] bq_t [$];

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;
  int   n_vec = 0;
  int   n_err = 0;

  logic       start_s[3], key_valid_s[3], key_last_s[3], din_valid_s[3], dout_ready_s[3];
  logic [7:0] key_data_s[3], din_data_s[3], dout_data_s[3];
  logic       key_ready_s[3], din_ready_s[3], dout_valid_s[3], busy_s[3], key_err_s[3];
  logic [2:0] dbg_s[3];

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1);
  end

  rc4_stream_engine #(.KEY_MAX(16), .DROP_N(0)) u0 (
    .clk(clk), .rst(rst), .start(start_s[0]),
    .key_valid(key_valid_s[0]), .key_ready(key_ready_s[0]), .key_data(key_data_s[0]), .key_last(key_last_s[0]),
    .din_valid(din_valid_s[0]), .din_ready(din_ready_s[0]), .din_data(din_data_s[0]),
    .dout_valid(dout_valid_s[0]), .dout_ready(dout_ready_s[0]), .dout_data(dout_data_s[0]),
    .busy(busy_s[0]), .key_err(key_err_s[0]), .dbg_state(dbg_s[0]));

  rc4_stream_engine #(.KEY_MAX(16), .DROP_N(3)) u1 (
    .clk(clk), .rst(rst), .start(start_s[1]),
    .key_valid(key_valid_s[1]), .key_ready(key_ready_s[1]), .key_data(key_data_s[1]), .key_last(key_last_s[1]),
    .din_valid(din_valid_s[1]), .din_ready(din_ready_s[1]), .din_data(din_data_s[1]),
    .dout_valid(dout_valid_s[1]), .dout_ready(dout_ready_s[1]), .dout_data(dout_data_s[1]),
    .busy(busy_s[1]), .key_err(key_err_s[1]), .dbg_state(dbg_s[1]));

  rc4_stream_engine #(.KEY_MAX(4), .DROP_N(0)) u2 (
    .clk(clk), .rst(rst), .start(start_s[2]),
    .key_valid(key_valid_s[2]), .key_ready(key_ready_s[2]), .key_data(key_data_s[2]), .key_last(key_last_s[2]),
    .din_valid(din_valid_s[2]), .din_ready(din_ready_s[2]), .din_data(din_data_s[2]),
    .dout_valid(dout_valid_s[2]), .dout_ready(dout_ready_s[2]), .dout_data(dout_data_s[2]),
    .busy(busy_s[2]), .key_err(key_err_s[2]), .dbg_state(dbg_s[2]));

  function automatic int drop_of(input int u);
    return (u == 1) ? 3 : 0;
  endfunction

  function automatic int kmax_of(input int u);
    return (u == 2) ? 4 : 16;
  endfunction

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // ---------------- reference model ----------------
  task automatic rc4_model(input bq_t key, input int drop, input int n, output bq_t ks);
    logic [7:0] s[256];
    logic [7:0] tmp;
    int i, j, t;
    ks = {};
    for (int k = 0; k < 256; k++) s[k] = k[7:0];
    j = 0;
    for (int k = 0; k < 256; k++) begin
      j = (j + int'(s[k]) + int'(key[k % key.size()])) % 256;
      tmp = s[k]; s[k] = s[j]; s[j] = tmp;
    end
    i = 0;
    j = 0;
    for (int k = 0; k < drop + n; k++) begin
      i = (i + 1) % 256;
      j = (j + int'(s[i])) % 256;
      tmp = s[i]; s[i] = s[j]; s[j] = tmp;
      t = (int'(s[i]) + int'(s[j])) % 256;
      if (k >= drop) ks.push_back(s[t]);
    end
  endtask

  task automatic str_to_q(input string s, output bq_t q);
    q = {};
    for (int k = 0; k < s.len(); k++) q.push_back(s[k]);
  endtask

  // ---------------- drivers ----------------
  task automatic idle_inputs(input int u);
    start_s[u] = 1'b0; key_valid_s[u] = 1'b0; key_last_s[u] = 1'b0; key_data_s[u] = 8'd0;
    din_valid_s[u] = 1'b0; din_data_s[u] = 8'd0; dout_ready_s[u] = 1'b1;
  endtask

  task automatic start_pulse(input int u);
    start_s[u] = 1'b1;
    @(posedge clk); #1;
    start_s[u] = 1'b0;
  endtask

  // Returns the cycle count at the edge that took the key_last byte.
  task automatic load_key(input int u, input bq_t key, output int t0);
    logic hs;
    for (int k = 0; k < key.size(); k++) begin
      key_valid_s[u] = 1'b0;
      repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
      key_valid_s[u] = 1'b1;
      key_data_s[u]  = key[k];
      key_last_s[u]  = (k == key.size() - 1);
      hs = 1'b0;
      for (int g = 0; g < 20 && !hs; g++) begin
        @(negedge clk);
        hs = key_ready_s[u];
        @(posedge clk); #1;
      end
      if (!hs) check("key_ready_wait", hs, 1'b1);
    end
    t0 = cyc;
    key_valid_s[u] = 1'b0;
    key_last_s[u]  = 1'b0;
  endtask

  // Streams pt through instance u and scoreboards dout against the model.
  task automatic run_stream(input int u, input bq_t key_eff, input bq_t pt, input int mode, input int t0);
    bq_t ks;
    logic [7:0] exp_q[$];
    int sent, n, drop;
    bit lat_done, done;
    logic pv, pr;
    n = pt.size();
    drop = drop_of(u);
    rc4_model(key_eff, drop, n, ks);
    exp_q = {};
    for (int k = 0; k < n; k++) exp_q.push_back(pt[k] ^ ks[k]);
    sent = 0; lat_done = 0; done = 0; pv = 0; pr = 0;
    din_valid_s[u] = 1'b1;
    din_data_s[u]  = pt[0];
    dout_ready_s[u] = 1'b1;
    for (int c = 0; c < 4000 && !done; c++) begin
      @(negedge clk);
      if (!lat_done && din_ready_s[u]) begin
        lat_done = 1;
        check("first_din_ready", cyc - t0, 770 + 2 * drop);
      end
      if (dout_valid_s[u]) begin
        if (pv && !pr) check("dout_held", dout_data_s[u], (exp_q.size() > 0) ? exp_q[0] : 8'h00);
        if (dout_ready_s[u]) begin
          if (exp_q.size() > 0) check("dout", dout_data_s[u], exp_q.pop_front());
          else                  check("dout_extra", dout_valid_s[u], 1'b0);
        end
      end else if (pv && !pr) begin
        check("dout_valid_held", dout_valid_s[u], 1'b1);
      end
      pv = dout_valid_s[u];
      pr = dout_ready_s[u];
      if (din_valid_s[u] && din_ready_s[u]) sent++;
      done = (sent == n) && (exp_q.size() == 0);
      @(posedge clk); #1;
      din_valid_s[u] = (sent < n) && (mode == 0 || $urandom_range(0, 3) != 0);
      if (sent < n) din_data_s[u] = pt[sent];
      case (mode)
        0:       dout_ready_s[u] = 1'b1;
        1:       dout_ready_s[u] = (cyc % 3 == 0);
        default: dout_ready_s[u] = 1'($urandom_range(0, 1));
      endcase
      // Stray key traffic outside LOAD must have no effect.
      key_valid_s[u] = (mode == 2) ? 1'($urandom_range(0, 1)) : 1'b0;
      key_last_s[u]  = key_valid_s[u];
      key_data_s[u]  = 8'($urandom_range(0, 255));
    end
    din_valid_s[u] = 1'b0; dout_ready_s[u] = 1'b1;
    key_valid_s[u] = 1'b0; key_last_s[u] = 1'b0;
    check("latency_seen", lat_done, 1'b1);
    check("all_out", exp_q.size(), 0);
    check("all_in", sent, n);
  endtask

  task automatic session(input int u, input bq_t key, input bq_t pt, input int mode);
    bq_t eff;
    int t0;
    start_pulse(u);
    @(negedge clk);
    check("start_clears_err", key_err_s[u], 1'b0);
    check("key_ready_load", key_ready_s[u], 1'b1);
    @(posedge clk); #1;
    load_key(u, key, t0);
    @(negedge clk);
    check("key_err", key_err_s[u], key.size() > kmax_of(u));
    check("busy", busy_s[u], 1'b1);
    eff = {};
    for (int k = 0; k < key.size() && k < kmax_of(u); k++) eff.push_back(key[k]);
    run_stream(u, eff, pt, mode, t0);
  endtask

  task automatic check_reset_outputs(input string tag);
    for (int u = 0; u < 3; u++) begin
      check({tag, "_key_ready"}, key_ready_s[u], 1'b0);
      check({tag, "_din_ready"}, din_ready_s[u], 1'b0);
      check({tag, "_dout_valid"}, dout_valid_s[u], 1'b0);
      check({tag, "_dout_data"}, dout_data_s[u], 8'h00);
      check({tag, "_busy"}, busy_s[u], 1'b0);
      check({tag, "_key_err"}, key_err_s[u], 1'b0);
      check({tag, "_state"}, dbg_s[u], ST_IDLE);
    end
  endtask

  // ---------------- main sequence ----------------
  initial begin
    bq_t k_key, k_wiki, k_secret, p_plain, p_pedia, p_attack, zeros, rk, rp, ks;
    int t0;
    logic hs;

    str_to_q("Key", k_key);
    str_to_q("Wiki", k_wiki);
    str_to_q("Secret", k_secret);
    str_to_q("Plaintext", p_plain);
    str_to_q("pedia", p_pedia);
    str_to_q("Attack at dawn", p_attack);
    zeros = {};
    for (int k = 0; k < 10; k++) zeros.push_back(8'h00);

    rst = 1'b1;
    for (int u = 0; u < 3; u++) idle_inputs(u);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check_reset_outputs("reset");
    @(posedge clk); #1;

    // Known-answer sessions.
    session(0, k_key, p_plain, 0);
    session(0, k_wiki, p_pedia, 2);
    session(0, k_secret, p_attack, 0);
    session(0, k_key, zeros, 1);
    session(1, k_key, zeros, 0);
    session(2, k_secret, p_attack, 2);
    start_pulse(2);
    @(negedge clk);
    check("err_cleared_by_start", key_err_s[2], 1'b0);
    @(posedge clk); #1;
    session(2, k_wiki, p_pedia, 0);

    // Abort during KSA, with din offered while not streaming.
    start_pulse(0);
    load_key(0, k_key, t0);
    din_valid_s[0] = 1'b1;
    din_data_s[0]  = 8'hAA;
    repeat (400) @(posedge clk);
    #1;
    @(negedge clk);
    check("abort_busy", busy_s[0], 1'b1);
    check("abort_din_ready", din_ready_s[0], 1'b0);
    check("abort_dout_valid", dout_valid_s[0], 1'b0);
    @(posedge clk); #1;
    din_valid_s[0] = 1'b0;
    session(0, k_wiki, p_pedia, 2);

    // Randomized sessions on every instance.
    for (int r = 0; r < 8; r++) begin
      int u;
      u = (r < 4) ? 0 : (r < 6) ? 1 : 2;
      rk = {};
      rp = {};
      repeat ($urandom_range(1, 20)) rk.push_back(8'($urandom_range(0, 255)));
      repeat ($urandom_range(1, 12)) rp.push_back(8'($urandom_range(0, 255)));
      session(u, rk, rp, $urandom_range(0, 2));
    end

    // Reset for one cycle while an output byte is held under back-pressure.
    start_pulse(0);
    load_key(0, k_key, t0);
    rc4_model(k_key, 0, 1, ks);
    dout_ready_s[0] = 1'b0;
    din_valid_s[0]  = 1'b1;
    din_data_s[0]   = 8'h55;
    hs = 1'b0;
    for (int c = 0; c < 1000 && !hs; c++) begin
      @(negedge clk);
      hs = din_ready_s[0];
      @(posedge clk); #1;
    end
    din_valid_s[0] = 1'b0;
    check("rst_setup_hs", hs, 1'b1);
    @(negedge clk);
    check("pre_rst_valid", dout_valid_s[0], 1'b1);
    check("pre_rst_data", dout_data_s[0], 8'h55 ^ ks[0]);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    dout_ready_s[0] = 1'b1;
    @(negedge clk);
    check_reset_outputs("mid_rst");
    @(posedge clk); #1;
    session(0, k_key, p_plain, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
